wb_ledmat_ctrl: RTL and testbench

Wishbone-controlled refresh engine for a MAX7219-style 8x8 LED matrix on the SPI peripheral's chip-select lines. The CPU writes an 8-row framebuffer and a control word through a Wishbone slave port. A Wishbone master port issues 16-bit write transactions to the SPI peripheral for device init, intensity updates, row refresh and shutdown. The block sits directly upstream of the SPI peripheral and is its only master for the matrix chip-select.

---
 rtl/wb_ledmat_pkg.sv | 65 ++++++
 rtl/wb_ledmat_regs.sv | 115 +++++++++++
 rtl/wb_ledmat_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_wb_ledmat_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ledmat_pkg.sv
// wb_ledmat_pkg
// Shared constants for the LED matrix refresh engine: MAX7219 register
// addresses, CTRL register bit positions, slave register indices, FSM state
// encoding and the chip-select address helper for the SPI peripheral.
package wb_ledmat_pkg;

  // MAX7219 register addresses (high byte of each 16-bit SPI word)
  localparam logic [7:0] MAX_NOOP      = 8'h00;
  localparam logic [7:0] MAX_DIGIT0    = 8'h01;
  localparam logic [7:0] MAX_DECODE    = 8'h09;
  localparam logic [7:0] MAX_INTENSITY = 8'h0A;
  localparam logic [7:0] MAX_SCANLIM   = 8'h0B;
  localparam logic [7:0] MAX_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] MAX_TEST      = 8'h0F;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_INT_LSB  = 8;
  localparam int CTRL_BUSY_BIT = 16;
  localparam int CTRL_INIT_BIT = 17;

  // Slave register word indices (s_adr_i[3:2])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_FB_LO  = 2'd1;
  localparam logic [1:0] REG_FB_HI  = 2'd2;
  localparam logic [1:0] REG_FRAMES = 2'd3;

  // Lowest address bit of the SPI peripheral's chip-select field
  localparam int SPI_CS_BIT_BASE = 4;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_INTEN = 3'd2;
  localparam logic [2:0] ST_ROWS  = 3'd3;
  localparam logic [2:0] ST_SHDN  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;

  // Chip-select lines are active-low: all three CS bits high except the
  // selected one.
  function automatic logic [31:0] spi_cs_addr(input logic [31:0] base,
                                              input int cs_sel);
    logic [31:0] a;
    a = base | (32'h7 << SPI_CS_BIT_BASE);
    a = a & ~(32'h1 << (SPI_CS_BIT_BASE + cs_sel));
    return a;
  endfunction

  // Device init sequence: wake, no decode, scan all 8 digits, intensity,
  // display-test off.
  function automatic logic [15:0] init_word(input logic [2:0] idx,
                                            input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {MAX_SHUTDOWN,  8'h01};
      3'd1:    w = {MAX_DECODE,    8'h00};
      3'd2:    w = {MAX_SCANLIM,   8'h07};
      3'd3:    w = {MAX_INTENSITY, 4'h0, intensity};
      3'd4:    w = {MAX_TEST,      8'h00};
      default: w = {MAX_NOOP,      8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_ledmat_regs.sv
// wb_ledmat_regs
// Wishbone slave register file for the LED matrix engine: CTRL, the 8-row
// framebuffer, the FRAMES counter and the fb/intensity dirty flags.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   reg_idx                  decoded word index (s_adr_i[3:2])
//   s_dat_i/we/sel/stb/cyc   slave write side
//   s_ack_o, s_dat_o         registered ack and read data
//   busy, init_done          status from the FSM (read-only CTRL bits)
//   fb_set, fb_clr, int_clr  dirty-flag control from the FSM
//   frame_inc                one pulse per completed refresh pass
//   enable, intensity, fb    register contents to the FSM
//   fb_dirty, int_dirty      pending-work flags to the FSM
module wb_ledmat_regs
  import wb_ledmat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  reg_idx,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  input  logic        busy,
  input  logic        init_done,
  input  logic        fb_set,
  input  logic        fb_clr,
  input  logic        int_clr,
  input  logic        frame_inc,
  output logic        enable,
  output logic [3:0]  intensity,
  output logic [63:0] fb,
  output logic        fb_dirty,
  output logic        int_dirty
);

  logic        access;
  logic        wr;
  logic        fb_touch;
  logic        int_change;
  logic [15:0] frames;
  logic [31:0] rd_data;

  // The ack-suppression term guarantees exactly one ack per access even when
  // the master keeps strobe high through the ack cycle.
  assign access     = s_stb_i & s_cyc_i & ~s_ack_o;
  assign wr         = access & s_we_i;
  assign fb_touch   = wr && (reg_idx == REG_FB_LO || reg_idx == REG_FB_HI)
                      && (s_sel_i != 4'b0000);
  assign int_change = wr && (reg_idx == REG_CTRL) && s_sel_i[1]
                      && (s_dat_i[CTRL_INT_LSB +: 4] != intensity);

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_data[CTRL_EN_BIT]        = enable;
        rd_data[CTRL_INT_LSB +: 4]  = intensity;
        rd_data[CTRL_BUSY_BIT]      = busy;
        rd_data[CTRL_INIT_BIT]      = init_done;
      end
      REG_FB_LO:  rd_data = fb[31:0];
      REG_FB_HI:  rd_data = fb[63:32];
      REG_FRAMES: rd_data = {16'h0000, frames};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_o <= 1'b0;
      s_dat_o <= '0;
    end else begin
      s_ack_o <= access;
      s_dat_o <= access ? rd_data : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      intensity <= 4'h0;
      fb        <= '0;
    end else if (wr) begin
      if (reg_idx == REG_CTRL) begin
        if (s_sel_i[0]) enable    <= s_dat_i[CTRL_EN_BIT];
        if (s_sel_i[1]) intensity <= s_dat_i[CTRL_INT_LSB +: 4];
      end
      for (int b = 0; b < 4; b++) begin
        if (s_sel_i[b]) begin
          if (reg_idx == REG_FB_LO) fb[b*8 +: 8]      <= s_dat_i[b*8 +: 8];
          if (reg_idx == REG_FB_HI) fb[32+b*8 +: 8]   <= s_dat_i[b*8 +: 8];
        end
      end
    end
  end

  // A set request in the same cycle as the FSM's clear wins, so a write
  // landing during a refresh pass is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_dirty  <= 1'b0;
      int_dirty <= 1'b0;
      frames    <= 16'h0000;
    end else begin
      fb_dirty  <= fb_touch | fb_set | (fb_dirty & ~fb_clr);
      int_dirty <= int_change | (int_dirty & ~int_clr);
      frames    <= frames + {15'b0, frame_inc};
    end
  end

endmodule

// File: rtl/wb_ledmat_ctrl.sv
// wb_ledmat_ctrl
// Refresh engine for a MAX7219-style 8x8 LED matrix. The CPU programs a
// framebuffer and control word over the Wishbone slave port; the FSM sends
// init, intensity, row and shutdown words to the SPI peripheral over the
// Wishbone master port, one 16-bit transaction per word.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   s_*             Wishbone slave (register access, only s_adr_i[3:2] used)
//   m_adr_o         SPI peripheral address with the chip-select pattern
//   m_dat_o         {16'h0, max7219_reg, value}
//   m_we_o, m_sel_o constant write, low two byte lanes
//   m_stb_o/m_cyc_o master strobe/cycle, masked in the ack cycle
//   m_ack_i         ack from the SPI peripheral
module wb_ledmat_ctrl
  import wb_ledmat_pkg::*;
#(
  parameter logic [31:0] SPI_BASE = 32'h0000_0000,
  parameter int          CS_SEL   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_stb_i,
  input  logic        s_cyc_i,
  output logic        s_ack_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i
);

  logic [2:0]  state;
  logic [2:0]  ret_state;
  logic [2:0]  idx;
  logic        stb_q;
  logic        init_done;
  logic        awake;
  logic        enable;
  logic [3:0]  intensity;
  logic [63:0] fb;
  logic        fb_dirty;
  logic        int_dirty;
  logic        busy;
  logic        fb_set;
  logic        fb_clr;
  logic        int_clr;
  logic        frame_inc;
  logic        ack_evt;
  logic        init_last;
  logic        go_shdn;
  logic        go_init;
  logic        go_inten;
  logic        go_rows;
  logic        unused_adr;

  assign unused_adr = ^{s_adr_i[31:4], s_adr_i[1:0]};

  wb_ledmat_regs u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_idx   (s_adr_i[3:2]),
    .s_dat_i   (s_dat_i),
    .s_we_i    (s_we_i),
    .s_sel_i   (s_sel_i),
    .s_stb_i   (s_stb_i),
    .s_cyc_i   (s_cyc_i),
    .s_ack_o   (s_ack_o),
    .s_dat_o   (s_dat_o),
    .busy      (busy),
    .init_done (init_done),
    .fb_set    (fb_set),
    .fb_clr    (fb_clr),
    .int_clr   (int_clr),
    .frame_inc (frame_inc),
    .enable    (enable),
    .intensity (intensity),
    .fb        (fb),
    .fb_dirty  (fb_dirty),
    .int_dirty (int_dirty)
  );

  assign busy    = (state != ST_IDLE);
  assign m_adr_o = spi_cs_addr(SPI_BASE, CS_SEL);
  assign m_we_o  = 1'b1;
  assign m_sel_o = 4'b0011;

  // The SPI peripheral is already idle in its ack cycle; hiding the strobe
  // there stops it from starting a second transfer of the same word.
  assign m_stb_o = stb_q & ~m_ack_i;
  assign m_cyc_o = stb_q & ~m_ack_i;

  // Shutdown keys off "awake" rather than init_done so that an INIT cut
  // short after the wake word still puts the device back to sleep.
  always_comb begin
    go_shdn   = !enable && awake;
    go_init   = enable && !init_done;
    go_inten  = enable && int_dirty;
    go_rows   = enable && fb_dirty;
    ack_evt   = (state == ST_WAIT) && m_ack_i;
    init_last = ack_evt && (ret_state == ST_INIT) && (idx == 3'd4);
    frame_inc = ack_evt && (ret_state == ST_ROWS) && (idx == 3'd7);
    fb_clr    = (state == ST_IDLE) && !go_shdn && !go_init && !go_inten
                && go_rows;
    int_clr   = (state == ST_INTEN) || init_last;
    // An aborted row pass leaves the display stale, so it is re-queued.
    fb_set    = init_last ||
                (ack_evt && (ret_state == ST_ROWS) && (idx != 3'd7) && !enable);
  end

  // Issuing states load one word and park in WAIT; WAIT resumes the
  // sequence at the next index once the peripheral acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      idx       <= 3'd0;
      stb_q     <= 1'b0;
      m_dat_o   <= '0;
      init_done <= 1'b0;
      awake     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= 3'd0;
          if (go_shdn)       state <= ST_SHDN;
          else if (go_init)  state <= ST_INIT;
          else if (go_inten) state <= ST_INTEN;
          else if (go_rows)  state <= ST_ROWS;
        end
        ST_INIT: begin
          m_dat_o   <= {16'h0000, init_word(idx, intensity)};
          stb_q     <= 1'b1;
          ret_state <= ST_INIT;
          state     <= ST_WAIT;
        end
        ST_INTEN: begin
          m_dat_o   <= {16'h0000, MAX_INTENSITY, 4'h0, intensity};
          stb_q     <= 1'b1;
          ret_state <= ST_INTEN;
          state     <= ST_WAIT;
        end
        ST_ROWS: begin
          m_dat_o   <= {16'h0000, MAX_DIGIT0 + {5'b0, idx}, fb[{idx, 3'b000} +: 8]};
          stb_q     <= 1'b1;
          ret_state <= ST_ROWS;
          state     <= ST_WAIT;
        end
        ST_SHDN: begin
          m_dat_o   <= {16'h0000, MAX_SHUTDOWN, 8'h00};
          stb_q     <= 1'b1;
          ret_state <= ST_SHDN;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (m_ack_i) begin
            stb_q <= 1'b0;
            case (ret_state)
              ST_INIT: begin
                if (idx == 3'd0) awake <= 1'b1;
                if (idx == 3'd4) begin
                  init_done <= 1'b1;
                  state     <= ST_IDLE;
                end else if (!enable) begin
                  state <= ST_IDLE;
                end else begin
                  idx   <= idx + 3'd1;
                  state <= ST_INIT;
                end
              end
              ST_ROWS: begin
                if (idx == 3'd7 || !enable) begin
                  state <= ST_IDLE;
                end else begin
                  idx   <= idx + 3'd1;
                  state <= ST_ROWS;
                end
              end
              ST_SHDN: begin
                init_done <= 1'b0;
                awake     <= 1'b0;
                state     <= ST_IDLE;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ledmat_ctrl.sv
// tb_wb_ledmat_ctrl
// Scoreboard bench: stimulus pushes the expected SPI words into exp_q, a
// cycle-accurate SPI peripheral model pops and compares each word as the
// DUT starts a transfer on the master port.
module tb_wb_ledmat_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_adr_i = '0;
  logic [31:0] s_dat_i = '0;
  logic        s_we_i = 1'b0;
  logic [3:0]  s_sel_i = '0;
  logic        s_stb_i = 1'b0;
  logic        s_cyc_i = 1'b0;
  logic        s_ack_o;
  logic [31:0] s_dat_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic        m_stb_o;
  logic        m_cyc_o;
  logic        m_ack_i;

  int tests_run = 0;
  int tests_failed = 0;
  int txn_count = 0;
  logic [15:0] exp_q[$];

  logic        req_seen = 1'b0;
  logic [31:0] cap_dat = '0;
  logic [31:0] cap_adr = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;
  logic        mdl_busy;
  int          mdl_cnt;

  always #5 clk = ~clk;

  wb_ledmat_ctrl #(.SPI_BASE(32'h0000_0000), .CS_SEL(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_adr_i (s_adr_i),
    .s_dat_i (s_dat_i),
    .s_we_i  (s_we_i),
    .s_sel_i (s_sel_i),
    .s_stb_i (s_stb_i),
    .s_cyc_i (s_cyc_i),
    .s_ack_o (s_ack_o),
    .s_dat_o (s_dat_o),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_stb_o (m_stb_o),
    .m_cyc_o (m_cyc_o),
    .m_ack_i (m_ack_i)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Compare one started transfer against the head of the scoreboard.
  task automatic scoreTxn();
    logic [15:0] exp_w;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected spi word: got 0x%08h, expected none", cap_dat);
    end else begin
      exp_w = exp_q.pop_front();
      checkOutput("spi word", cap_dat, {16'h0000, exp_w});
      checkOutput("spi addr", cap_adr, 32'h0000_0060);
      checkOutput("spi we/sel", {27'b0, cap_we, cap_sel}, {27'b0, 1'b1, 4'b0011});
    end
  endtask

  // Master port sampled mid-cycle; the peripheral model acts on it at the
  // next rising edge like a registered slave would.
  always @(negedge clk) begin
    req_seen = m_cyc_o && m_stb_o;
    cap_dat  = m_dat_o;
    cap_adr  = m_adr_o;
    cap_we   = m_we_o;
    cap_sel  = m_sel_o;
  end

  // SPI peripheral: idle -> 3 busy cycles -> 1 ack cycle (idle again).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
      m_ack_i  <= 1'b0;
    end else begin
      m_ack_i <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          mdl_busy <= 1'b0;
          m_ack_i  <= 1'b1;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (req_seen) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 2;
        txn_count++;
        scoreTxn();
      end
    end
  end

  task automatic busAccess(input logic [1:0] idx, input logic we,
                           input logic [31:0] data, input logic [3:0] sel,
                           output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    @(negedge clk);
    s_adr_i = {28'h0, idx, 2'b00};
    s_dat_i = data;
    s_we_i  = we;
    s_sel_i = sel;
    s_stb_i = 1'b1;
    s_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (s_ack_o) begin
        got   = 1'b1;
        rdata = s_dat_o;
      end
    end
    s_stb_i = 1'b0;
    s_cyc_i = 1'b0;
    s_we_i  = 1'b0;
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL slave ack: got none, expected ack within 8 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic [31:0] data,
                               input logic [3:0] sel);
    logic [31:0] dummy;
    busAccess(idx, 1'b1, data, sel, dummy);
  endtask

  task automatic checkRead(input logic [1:0] idx, input logic [31:0] expected,
                           input string name);
    logic [31:0] rd;
    busAccess(idx, 1'b0, 32'h0, 4'hF, rd);
    checkOutput(name, rd, expected);
  endtask

  task automatic pushWords(input logic [15:0] words[$]);
    foreach (words[i]) exp_q.push_back(words[i]);
  endtask

  // Wait for the scoreboard to empty, then stay quiet long enough to catch
  // any extra transfer.
  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("words left in scoreboard", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (40) @(negedge clk);
  endtask

  task automatic waitTxn(input int target, input int budget);
    for (int i = 0; i < budget && txn_count < target; i++) @(negedge clk);
    if (txn_count < target) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL transfer wait: got %0d transfers, expected %0d", txn_count, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    // Reset state
    repeat (4) @(negedge clk);
    checkOutput("reset outputs", {29'b0, m_cyc_o, m_stb_o, s_ack_o}, 32'h0);
    checkOutput("reset m_dat_o", m_dat_o, 32'h0);
    rst_n = 1'b1;
    checkRead(2'd0, 32'h0, "reset CTRL");
    checkRead(2'd1, 32'h0, "reset FB_LO");
    checkRead(2'd2, 32'h0, "reset FB_HI");
    checkRead(2'd3, 32'h0, "reset FRAMES");
    repeat (100) @(negedge clk);
    checkOutput("idle transfers", txn_count, 32'd0);

    // Enable with intensity 5: full init then one blank pass
    pushWords('{16'h0C01, 16'h0900, 16'h0B07, 16'h0A05, 16'h0F00,
                16'h0100, 16'h0200, 16'h0300, 16'h0400,
                16'h0500, 16'h0600, 16'h0700, 16'h0800});
    applyStimulus(2'd0, 32'h0000_0501, 4'hF);
    waitDrain(1500);
    checkRead(2'd3, 32'd1, "FRAMES after init");
    checkRead(2'd0, 32'h0002_0501, "CTRL after init");

    // FB_LO write lands during row 2: row 3 picks it up, then a second pass
    base = txn_count;
    pushWords('{16'h0100, 16'h0200, 16'h0300, 16'h0444,
                16'h0500, 16'h0600, 16'h0700, 16'h0800,
                16'h0111, 16'h0222, 16'h0333, 16'h0444,
                16'h0500, 16'h0600, 16'h0700, 16'h0800});
    applyStimulus(2'd2, 32'h0000_0000, 4'hF);
    waitTxn(base + 3, 400);
    applyStimulus(2'd1, 32'h4433_2211, 4'hF);
    waitDrain(2000);
    checkRead(2'd3, 32'd3, "FRAMES after two passes");
    checkOutput("two-pass transfer count", txn_count - base, 32'd16);

    // Intensity change while idle: one word, no rows
    base = txn_count;
    pushWords('{16'h0A0C});
    applyStimulus(2'd0, 32'h0000_0C01, 4'b0011);
    waitDrain(500);
    checkOutput("intensity transfer count", txn_count - base, 32'd1);

    // Single byte lane to FB_HI: only row 6 changes
    base = txn_count;
    pushWords('{16'h0111, 16'h0222, 16'h0333, 16'h0444,
                16'h0500, 16'h0600, 16'h07AA, 16'h0800});
    applyStimulus(2'd2, 32'h00AA_0000, 4'b0100);
    waitDrain(1000);
    checkOutput("row pass chip-selects", txn_count - base, 32'd8);
    checkRead(2'd2, 32'h00AA_0000, "FB_HI after byte write");
    checkRead(2'd1, 32'h4433_2211, "FB_LO unchanged");
    checkRead(2'd3, 32'd4, "FRAMES after byte write");

    // Disable while running: shutdown word, init_done drops
    pushWords('{16'h0C00});
    applyStimulus(2'd0, 32'h0000_0C00, 4'b0001);
    waitDrain(500);
    checkRead(2'd0, 32'h0000_0C00, "CTRL after shutdown");

    // Re-enable, then disable during the first INIT word
    base = txn_count;
    pushWords('{16'h0C01, 16'h0C00});
    applyStimulus(2'd0, 32'h0000_0C01, 4'b0001);
    waitTxn(base + 1, 200);
    applyStimulus(2'd0, 32'h0000_0C00, 4'b0001);
    waitDrain(500);
    checkOutput("aborted init transfers", txn_count - base, 32'd2);
    checkRead(2'd0, 32'h0000_0C00, "CTRL after aborted init");

    // Re-enable re-runs the full init and refreshes the stored frame
    pushWords('{16'h0C01, 16'h0900, 16'h0B07, 16'h0A0C, 16'h0F00,
                16'h0111, 16'h0222, 16'h0333, 16'h0444,
                16'h0500, 16'h0600, 16'h07AA, 16'h0800});
    applyStimulus(2'd0, 32'h0000_0C01, 4'b0001);
    waitDrain(1500);
    checkRead(2'd0, 32'h0002_0C01, "CTRL after re-init");
    checkRead(2'd3, 32'd5, "FRAMES after re-init");

    // Async reset in the middle of a transfer
    base = txn_count;
    pushWords('{16'h0111, 16'h0222, 16'h0333, 16'h0444,
                16'h0500, 16'h0600, 16'h07AA, 16'h0800});
    applyStimulus(2'd1, 32'h4433_2211, 4'hF);
    waitTxn(base + 1, 200);
    checkOutput("cyc high mid transfer", {31'b0, m_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset drops cyc/stb", {30'b0, m_cyc_o, m_stb_o}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkRead(2'd0, 32'h0, "CTRL after mid reset");
    checkRead(2'd3, 32'h0, "FRAMES after mid reset");
    repeat (50) @(negedge clk);
    checkOutput("no transfers after reset", txn_count - base, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
